// File: rtl/quad_decoder_multi_if.sv
// -----------------------------------------------------------------------------
// quad_decoder_multi_if
//   Bundles the encoder-pin inputs, control strobes and decoded outputs of
//   quad_decoder_multi so the decoder and its user share one port.
//
//   Parameters : CHANNELS, POS_W (must match the decoder instance)
//   Signals    : quad_in  [2*CHANNELS]     raw pins, ch n: bit 2n = A, 2n+1 = B
//                clear    [CHANNELS]       synchronous position clear
//                err_clr  [CHANNELS]       synchronous error-flag clear
//                pos_out  [CHANNELS*POS_W] detent positions
//                step_cw  [CHANNELS]       one-cycle detent-increment pulse
//                step_ccw [CHANNELS]       one-cycle detent-decrement pulse
//                err      [CHANNELS]       sticky illegal-transition flag
//                vel_out  [CHANNELS*8]     detents per window (QDEC_VELOCITY_EN)
//   Modports   : master drives pins/strobes, slave is the decoder.
// -----------------------------------------------------------------------------
interface quad_decoder_multi_if #(
  parameter int CHANNELS = 2,
  parameter int POS_W    = 8
);
  logic [2*CHANNELS-1:0]     quad_in;
  logic [CHANNELS-1:0]       clear;
  logic [CHANNELS-1:0]       err_clr;
  logic [CHANNELS*POS_W-1:0] pos_out;
  logic [CHANNELS-1:0]       step_cw;
  logic [CHANNELS-1:0]       step_ccw;
  logic [CHANNELS-1:0]       err;
`ifdef QDEC_VELOCITY_EN
  logic [CHANNELS*8-1:0]     vel_out;

  modport master (
    output quad_in, clear, err_clr,
    input  pos_out, step_cw, step_ccw, err, vel_out
  );
  modport slave (
    input  quad_in, clear, err_clr,
    output pos_out, step_cw, step_ccw, err, vel_out
  );
`else
  modport master (
    output quad_in, clear, err_clr,
    input  pos_out, step_cw, step_ccw, err
  );
  modport slave (
    input  quad_in, clear, err_clr,
    output pos_out, step_cw, step_ccw, err
  );
`endif
endinterface

// File: rtl/quad_decoder_multi.sv
// -----------------------------------------------------------------------------
// quad_decoder_multi
//   Multi-channel quadrature (rotary encoder) decoder. Per channel:
//   2-flop synchroniser and per-bit debouncer on A/B, Gray-code decode into an
//   up/down sub-step counter, detent position taken as the counter's upper
//   POS_W bits (wrap or saturate), one-cycle detent pulses and a sticky flag
//   for illegal double-edge transitions.
//
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset
//     bus  - quad_decoder_multi_if.slave (pins, clear, err_clr, pos_out,
//            step_cw, step_ccw, err[, vel_out])
//
//   Optional feature (macro QDEC_VELOCITY_EN): adds parameter WIN_LOG2 and
//   drives bus.vel_out with the number of detent pulses per channel seen in
//   each 2^WIN_LOG2-clock window (saturating at 255).
// -----------------------------------------------------------------------------
module quad_decoder_multi #(
  parameter int CHANNELS   = 2,
  parameter int POS_W      = 8,
  parameter int STEPS_LOG2 = 2,
  parameter int DEB_CYCLES = 4,
  parameter int SATURATE   = 0
`ifdef QDEC_VELOCITY_EN
  ,
  parameter int WIN_LOG2   = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  quad_decoder_multi_if.slave  bus
);

  localparam int              CNT_W    = POS_W + STEPS_LOG2;
  localparam logic [7:0]      DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Synchroniser fill tracker: sync2 only carries real pin values from the
  // second edge after reset, so priming must not look at it before then.
  logic [1:0] fill_q, fill_d;
  logic       sync_ready;

  always_comb begin
    fill_d = fill_q;
    if (fill_q != 2'd2) fill_d = fill_q + 2'd1;
  end

  assign sync_ready = (fill_q == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fill_q <= '0;
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge value of the others, independent of statement order.
    else     fill_q <= fill_d;
  end

  logic [CHANNELS-1:0]       cw_vec;
  logic [CHANNELS-1:0]       ccw_vec;
  logic [CHANNELS-1:0]       err_vec;
  logic [CHANNELS*POS_W-1:0] pos_vec;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    // Bit 0 = A, bit 1 = B throughout.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      deb_q, deb_d;
    logic [1:0][7:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]      prev_q, prev_d;
    logic            primed_q, primed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            cw_q, cw_d, ccw_q, ccw_d, err_q, err_d;

    logic a_chg, b_chg, dir_ccw, step_up, step_dn, illegal;
    logic [CNT_W-1:0] cnt_up, cnt_dn;

    // Debounce: a bit follows its synced value only after DEB_CYCLES
    // consecutive disagreeing clocks; any agreement restarts the count.
    always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch
      // is inferred.
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] == deb_q[b]) begin
          deb_cnt_d[b] = '0;
        end else if (deb_cnt_q[b] == DEB_LAST) begin
          deb_d[b]     = sync2_q[b];
          deb_cnt_d[b] = '0;
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + 8'd1;
        end
      end
    end

    // Quadrature decode. A legal move changes exactly one bit; its direction
    // is A(prev) xor B(now): 0 for the 00->10->11->01 sequence, 1 for reverse.
    assign a_chg   = prev_q[0] ^ deb_q[0];
    assign b_chg   = prev_q[1] ^ deb_q[1];
    assign dir_ccw = prev_q[0] ^ deb_q[1];
    assign step_up = primed_q & (a_chg ^ b_chg) & ~dir_ccw;
    assign step_dn = primed_q & (a_chg ^ b_chg) &  dir_ccw;
    assign illegal = primed_q & a_chg & b_chg;

    // Saturate mode clamps the full sub-step counter; wrap mode relies on
    // natural modulo-2^CNT_W arithmetic.
    always_comb begin
      cnt_up = cnt_q + 1'b1;
      cnt_dn = cnt_q - 1'b1;
      if (SATURATE != 0) begin
        if (cnt_q == CNT_MAX) cnt_up = cnt_q;
        if (cnt_q == '0)      cnt_dn = cnt_q;
      end
    end

    always_comb begin
      prev_d   = prev_q;
      primed_d = primed_q;
      cnt_d    = cnt_q;
      cw_d     = 1'b0;
      ccw_d    = 1'b0;
      err_d    = err_q;

      if (!primed_q) begin
        // Prime from the first settled debounced sample: synchroniser filled
        // and no debounce change pending, so the initial pin state is never
        // mistaken for a transition from the reset value.
        if (sync_ready && (sync2_q == deb_q)) begin
          prev_d   = deb_q;
          primed_d = 1'b1;
        end
      end else begin
        prev_d = deb_q;
        if (step_up) begin
          cnt_d = cnt_up;
          cw_d  = (cnt_up[CNT_W-1:STEPS_LOG2] != cnt_q[CNT_W-1:STEPS_LOG2]);
        end else if (step_dn) begin
          cnt_d = cnt_dn;
          ccw_d = (cnt_dn[CNT_W-1:STEPS_LOG2] != cnt_q[CNT_W-1:STEPS_LOG2]);
        end
      end

      // A new illegal transition outranks a simultaneous clear request.
      if (bus.err_clr[n]) err_d = 1'b0;
      if (illegal)        err_d = 1'b1;

      // Clear outranks a same-cycle step and swallows its pulse.
      if (bus.clear[n]) begin
        cnt_d = '0;
        cw_d  = 1'b0;
        ccw_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q   <= '0;
        sync2_q   <= '0;
        deb_q     <= '0;
        deb_cnt_q <= '0;
        prev_q    <= '0;
        primed_q  <= 1'b0;
        cnt_q     <= '0;
        cw_q      <= 1'b0;
        ccw_q     <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        sync1_q   <= bus.quad_in[2*n +: 2];
        sync2_q   <= sync1_q;
        deb_q     <= deb_d;
        deb_cnt_q <= deb_cnt_d;
        prev_q    <= prev_d;
        primed_q  <= primed_d;
        cnt_q     <= cnt_d;
        cw_q      <= cw_d;
        ccw_q     <= ccw_d;
        err_q     <= err_d;
      end
    end

    assign cw_vec[n]                  = cw_q;
    assign ccw_vec[n]                 = ccw_q;
    assign err_vec[n]                 = err_q;
    assign pos_vec[n*POS_W +: POS_W]  = cnt_q[CNT_W-1:STEPS_LOG2];
  end

  assign bus.step_cw  = cw_vec;
  assign bus.step_ccw = ccw_vec;
  assign bus.err      = err_vec;
  assign bus.pos_out  = pos_vec;

`ifdef QDEC_VELOCITY_EN
  // Free-running measurement window shared by all channels.
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic                win_end;

  assign win_d   = win_q + 1'b1;
  assign win_end = &win_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_q <= '0;
    else     win_q <= win_d;
  end

  logic [CHANNELS*8-1:0] vel_vec;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_vel
    logic [7:0] acc_q, acc_d, vel_q, vel_d, acc_inc;

    // The pulse on the window's last cycle is folded into the value that
    // gets published, then the accumulator restarts from zero.
    always_comb begin
      acc_inc = acc_q;
      if ((cw_vec[n] | ccw_vec[n]) && (acc_q != 8'hFF)) acc_inc = acc_q + 8'd1;
      acc_d = acc_inc;
      vel_d = vel_q;
      if (win_end) begin
        vel_d = acc_inc;
        acc_d = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
        vel_q <= '0;
      end else begin
        acc_q <= acc_d;
        vel_q <= vel_d;
      end
    end

    assign vel_vec[n*8 +: 8] = vel_q;
  end

  assign bus.vel_out = vel_vec;
`endif

endmodule
